// File: rtl/alu_bist_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_bist_if
// Description : Bus bundle between the ALU BIST initiator and its environment.
//               The master side is the BIST engine. It drives ALU operands and
//               reports status. The slave side supplies start and the ALU result.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_bist_if;
    logic        start;
    logic [31:0] alu_res;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic        busy;
    logic        done;
    logic        pass;
    logic [3:0]  err_count;
    logic [3:0]  fail_idx;
    logic [3:0]  vec_idx;

    modport master (
        input  start, alu_res,
        output alu_a, alu_b, alu_op, busy, done, pass, err_count, fail_idx, vec_idx
    );

    modport slave (
        output start, alu_res,
        input  alu_a, alu_b, alu_op, busy, done, pass, err_count, fail_idx, vec_idx
    );
endinterface
`default_nettype wire

// File: rtl/alu_bist.sv
`default_nettype none
// ============================================================================
// Module      : alu_bist
// Description : Built-in self-test initiator for the RV32I ALU. It walks a
//               fixed 12-entry vector table and holds each vector for
//               SETTLE_CYCLES. It then checks the ALU result against a golden
//               value and reports pass/fail, an error count and the first
//               failing index.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_bist #(
    parameter int unsigned SETTLE_CYCLES = 1   // legal range 1..15
) (
    input  wire logic      clk,
    input  wire logic      rst,
    alu_bist_if.master     bus
);

    localparam int unsigned NUM_VEC  = 12;
    localparam logic [3:0]  C_NO_FAIL = 4'hF;
    localparam logic [3:0]  C_LAST    = 4'(NUM_VEC - 1);
    localparam logic [3:0]  C_SETTLE  = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Stimulus table: {op, A, B}
    function automatic logic [67:0] vec_stim(input logic [3:0] idx);
        case (idx)
            4'd0:    vec_stim = {4'b0000, 32'h0000000A, 32'h00000005};
            4'd1:    vec_stim = {4'b1000, 32'h0000000A, 32'h00000014};
            4'd2:    vec_stim = {4'b0001, 32'h00000003, 32'h00000002};
            4'd3:    vec_stim = {4'b0010, 32'hFFFFFFFB, 32'h00000003};
            4'd4:    vec_stim = {4'b0011, 32'hFFFFFFFB, 32'h00000003};
            4'd5:    vec_stim = {4'b0100, 32'hF0F0F0F0, 32'h0F0F0F0F};
            4'd6:    vec_stim = {4'b1101, 32'hFFFFFFC0, 32'h00000003};
            4'd7:    vec_stim = {4'b0110, 32'hAAAA0000, 32'h0000BBBB};
            4'd8:    vec_stim = {4'b0111, 32'hFFFF0000, 32'h00FF00FF};
            4'd9:    vec_stim = {4'b1001, 32'h12345678, 32'h87654321};
            4'd10:   vec_stim = {4'b0101, 32'hFFFFFFC0, 32'h00000003};
            4'd11:   vec_stim = {4'b1000, 32'h00000005, 32'h00000005};
            default: vec_stim = '0;
        endcase
    endfunction

    // Golden result for each table entry
    function automatic logic [31:0] vec_golden(input logic [3:0] idx);
        case (idx)
            4'd0:    vec_golden = 32'h0000000F;
            4'd1:    vec_golden = 32'hFFFFFFF6;
            4'd2:    vec_golden = 32'h0000000C;
            4'd3:    vec_golden = 32'h00000001;
            4'd4:    vec_golden = 32'h00000000;
            4'd5:    vec_golden = 32'hFFFFFFFF;
            4'd6:    vec_golden = 32'hFFFFFFF8;
            4'd7:    vec_golden = 32'hAAAABBBB;
            4'd8:    vec_golden = 32'h00FF0000;
            4'd9:    vec_golden = 32'h87654321;
            4'd10:   vec_golden = 32'h1FFFFFF8;
            4'd11:   vec_golden = 32'h00000000;
            default: vec_golden = 32'h00000000;
        endcase
    endfunction

    state_t      state_q,     state_d;
    logic [31:0] alu_a_q,     alu_a_d;
    logic [31:0] alu_b_q,     alu_b_d;
    logic [3:0]  alu_op_q,    alu_op_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;
    logic        pass_q,      pass_d;
    logic [3:0]  err_count_q, err_count_d;
    logic [3:0]  fail_idx_q,  fail_idx_d;
    logic [3:0]  vec_idx_q,   vec_idx_d;
    logic [3:0]  settle_q,    settle_d;

    logic        w_launch;
    logic        w_mismatch;
    logic [67:0] w_next_stim;
    logic [67:0] w_first_stim;

    assign w_launch     = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign w_mismatch   = (bus.alu_res != vec_golden(vec_idx_q));
    assign w_next_stim  = vec_stim(4'(vec_idx_q + 4'd1));
    assign w_first_stim = vec_stim(4'd0);

    // Next-state and next-output computation for the BIST sequencer
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        fail_idx_d  = fail_idx_q;
        vec_idx_d   = vec_idx_q;
        settle_d    = settle_q;

        case (state_q)
            S_IDLE: begin
                alu_a_d  = '0;
                alu_b_d  = '0;
                alu_op_d = '0;
            end
            S_APPLY: begin
                // Counter was loaded with SETTLE_CYCLES when the vector went out
                if (settle_q <= 4'd1) begin
                    settle_d = 4'd0;
                    state_d  = S_CHECK;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            S_CHECK: begin
                if (w_mismatch) begin
                    if (err_count_q != 4'hF) begin
                        err_count_d = err_count_q + 4'd1;
                    end
                    if (fail_idx_q == C_NO_FAIL) begin
                        fail_idx_d = vec_idx_q;
                    end
                end
                if (vec_idx_q == C_LAST) begin
                    state_d  = S_DONE;
                    alu_a_d  = '0;
                    alu_b_d  = '0;
                    alu_op_d = '0;
                end else begin
                    vec_idx_d = vec_idx_q + 4'd1;
                    alu_op_d  = w_next_stim[67:64];
                    alu_a_d   = w_next_stim[63:32];
                    alu_b_d   = w_next_stim[31:0];
                    settle_d  = C_SETTLE;
                    state_d   = S_APPLY;
                end
            end
            S_DONE: begin
                // Final error count was committed by the last CHECK
                busy_d   = 1'b0;
                done_d   = 1'b1;
                pass_d   = (err_count_q == 4'd0);
                alu_a_d  = '0;
                alu_b_d  = '0;
                alu_op_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new run clears the previous results on the same edge
        if (w_launch) begin
            state_d     = S_APPLY;
            vec_idx_d   = 4'd0;
            alu_op_d    = w_first_stim[67:64];
            alu_a_d     = w_first_stim[63:32];
            alu_b_d     = w_first_stim[31:0];
            settle_d    = C_SETTLE;
            err_count_d = 4'd0;
            fail_idx_d  = C_NO_FAIL;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            busy_d      = 1'b1;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= 4'd0;
            fail_idx_q  <= C_NO_FAIL;
            vec_idx_q   <= 4'd0;
            settle_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            fail_idx_q  <= fail_idx_d;
            vec_idx_q   <= vec_idx_d;
            settle_q    <= settle_d;
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_count_q;
    assign bus.fail_idx  = fail_idx_q;
    assign bus.vec_idx   = vec_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_bist.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_bist
// Description : Scoreboard bench for alu_bist with a behavioural ALU that can
//               inject faults. Two instances: SETTLE_CYCLES=1 and 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_bist;

    typedef struct {
        logic       pass;
        logic [3:0] err;
        logic [3:0] fidx;
        int         lat;
        int         k;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [1:0] fault0 = 2'd0;   // 0: correct, 1: XOR bit0 flip, 2: always zero
    logic [1:0] fault1 = 2'd0;

    exp_t       sb0[$];
    exp_t       sb1[$];
    logic [7:0] ops0[$];         // {vec_idx, op}

    alu_bist_if if0 ();
    alu_bist_if if1 ();

    alu_bist #(.SETTLE_CYCLES(1)) dut0 (.clk(clk), .rst(rst), .bus(if0.master));
    alu_bist #(.SETTLE_CYCLES(3)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [1:0] fault);
        logic [31:0] r;
        case (op)
            4'b0000: r = a + b;
            4'b0001: r = a << b[4:0];
            4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: r = (a < b) ? 32'd1 : 32'd0;
            4'b0100: r = a ^ b;
            4'b0101: r = a >> b[4:0];
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            4'b1000: r = a - b;
            4'b1001: r = b;
            4'b1101: r = $signed(a) >>> b[4:0];
            default: r = 32'd0;
        endcase
        if (fault == 2'd1 && op == 4'b0100) r = r ^ 32'd1;
        if (fault == 2'd2) r = 32'd0;
        return r;
    endfunction

    assign if0.alu_res = alu_model(if0.alu_op, if0.alu_a, if0.alu_b, fault0);
    assign if1.alu_res = alu_model(if1.alu_op, if1.alu_a, if1.alu_b, fault1);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: instance 0
    logic       p0_busy = 1'b0, p0_done = 1'b0;
    logic [3:0] p0_vidx = 4'd0;
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] o;
        if (!rst) begin
            if (if0.busy && (!p0_busy || if0.vec_idx != p0_vidx) && ops0.size() > 0) begin
                o = ops0.pop_front();
                chk("op_seq_idx", {28'd0, if0.vec_idx}, {28'd0, o[7:4]});
                chk("op_seq_op", {28'd0, if0.alu_op}, {28'd0, o[3:0]});
            end
            if (if0.done && !p0_done) begin
                if (sb0.size() == 0) begin
                    chk("unexpected_done0", 32'd1, 32'd0);
                end else begin
                    e = sb0.pop_front();
                    chk("d0_pass", {31'd0, if0.pass}, {31'd0, e.pass});
                    chk("d0_err_count", {28'd0, if0.err_count}, {28'd0, e.err});
                    chk("d0_fail_idx", {28'd0, if0.fail_idx}, {28'd0, e.fidx});
                    chk("d0_latency", 32'(cyc - e.k), 32'(e.lat));
                    chk("d0_busy_low", {31'd0, if0.busy}, 32'd0);
                end
            end
        end
        p0_busy = if0.busy;
        p0_done = if0.done;
        p0_vidx = if0.vec_idx;
    end

    // Monitor: instance 1
    logic p1_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && if1.done && !p1_done) begin
            if (sb1.size() == 0) begin
                chk("unexpected_done1", 32'd1, 32'd0);
            end else begin
                e = sb1.pop_front();
                chk("d1_pass", {31'd0, if1.pass}, {31'd0, e.pass});
                chk("d1_err_count", {28'd0, if1.err_count}, {28'd0, e.err});
                chk("d1_fail_idx", {28'd0, if1.fail_idx}, {28'd0, e.fidx});
                chk("d1_latency", 32'(cyc - e.k), 32'(e.lat));
            end
        end
        p1_done = if1.done;
    end

    // Pulse start for one cycle on the chosen instance; k is the sampling edge
    task automatic pulse_start(input int sel, output int k);
        @(negedge clk);
        if (sel == 0) if0.start = 1'b1; else if1.start = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        if0.start = 1'b0;
        if1.start = 1'b0;
    endtask

    task automatic wait_done(input int sel);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((sel == 0 && if0.done) || (sel == 1 && if1.done)) return;
        end
        chk("wait_done_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_reset0(input string tag);
        chk({tag, "_busy"},  {31'd0, if0.busy}, 32'd0);
        chk({tag, "_done"},  {31'd0, if0.done}, 32'd0);
        chk({tag, "_pass"},  {31'd0, if0.pass}, 32'd0);
        chk({tag, "_err"},   {28'd0, if0.err_count}, 32'd0);
        chk({tag, "_fidx"},  {28'd0, if0.fail_idx}, 32'hF);
        chk({tag, "_vidx"},  {28'd0, if0.vec_idx}, 32'd0);
        chk({tag, "_a"},     if0.alu_a, 32'd0);
        chk({tag, "_b"},     if0.alu_b, 32'd0);
        chk({tag, "_op"},    {28'd0, if0.alu_op}, 32'd0);
    endtask

    initial begin
        int         k;
        logic [3:0] op_tbl [12];
        op_tbl = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'hD, 4'h6, 4'h7, 4'h9, 4'h5, 4'h8};
        if0.start = 1'b0;
        if1.start = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset0("rst");
        @(negedge clk);
        rst = 1'b0;

        // Run 1: correct ALU, op sequence checked, start re-pulsed while busy
        fault0 = 2'd0;
        for (int i = 0; i < 12; i++) ops0.push_back({4'(i), op_tbl[i]});
        pulse_start(0, k);
        sb0.push_back('{pass: 1'b1, err: 4'd0, fidx: 4'hF, lat: 25, k: k});
        repeat (6) @(negedge clk);
        chk("busy_mid_run", {31'd0, if0.busy}, 32'd1);
        pulse_start(0, k);   // ignored: latency of run 1 must remain 25
        wait_done(0);

        // Run 2: XOR bit-0 fault
        fault0 = 2'd1;
        pulse_start(0, k);
        sb0.push_back('{pass: 1'b0, err: 4'd1, fidx: 4'd5, lat: 25, k: k});
        wait_done(0);

        // Run 3: always-zero ALU, started from DONE; results clear on that edge
        fault0 = 2'd2;
        pulse_start(0, k);
        chk("restart_done", {31'd0, if0.done}, 32'd0);
        chk("restart_err", {28'd0, if0.err_count}, 32'd0);
        chk("restart_vidx", {28'd0, if0.vec_idx}, 32'd0);
        chk("restart_busy", {31'd0, if0.busy}, 32'd1);
        chk("restart_fidx", {28'd0, if0.fail_idx}, 32'hF);
        sb0.push_back('{pass: 1'b0, err: 4'd10, fidx: 4'd0, lat: 25, k: k});
        wait_done(0);

        // Run 4: reset mid-run at vec_idx 6, then a clean run
        fault0 = 2'd0;
        pulse_start(0, k);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                if (if0.vec_idx == 4'd6) seen = 1'b1;
            end
            chk("reach_vidx6", {31'd0, seen}, 32'd1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset0("midrst");
        @(negedge clk);
        rst = 1'b0;
        pulse_start(0, k);
        sb0.push_back('{pass: 1'b1, err: 4'd0, fidx: 4'hF, lat: 25, k: k});
        wait_done(0);

        // Instance with SETTLE_CYCLES=3
        fault1 = 2'd0;
        pulse_start(1, k);
        sb1.push_back('{pass: 1'b1, err: 4'd0, fidx: 4'hF, lat: 49, k: k});
        wait_done(1);

        repeat (3) @(negedge clk);
        chk("sb0_drained", 32'(sb0.size()), 32'd0);
        chk("sb1_drained", 32'(sb1.size()), 32'd0);
        chk("ops_drained", 32'(ops0.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Built-in self-test initiator for the RV32I ALU.
- It drives the ALU operand and opcode inputs from a fixed internal vector table, samples the ALU result, compares it against golden values, and reports pass/fail with an error count and the index of the first failure.
- It sits beside the combinational ALU in the single-cycle core and is used at bring-up and in regression to check the ALU without an external bench.

Parameters:
- SETTLE_CYCLES, 1, number of cycles each vector is held on the ALU inputs before the result is sampled; legal range 1..15.
- NUM_VEC, 12, number of table entries executed; fixed by the table below, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a test run.
- alu_res  input  32  result returned by the ALU (ALURes).
- alu_a  output  32  operand A driven to the ALU.
- alu_b  output  32  operand B driven to the ALU.
- alu_op  output  4  ALUOp driven to the ALU.
- busy  output  1  high while a run is in progress.
- done  output  1  high once a run has completed; held until the next start.
- pass  output  1  valid when done=1; high if err_count==0.
- err_count  output  4  number of mismatching vectors; saturates at 15.
- fail_idx  output  4  index of the first failing vector; 4'hF means no failure.
- vec_idx  output  4  index of the vector currently applied.

Behaviour:
- Reset, applied synchronously at any time including mid-run:
  - state goes to IDLE.
  - alu_a=0, alu_b=0, alu_op=4'b0000.
  - busy=0, done=0, pass=0, err_count=0, fail_idx=4'hF, vec_idx=0, settle counter=0.
- All outputs are registered. No combinational path exists from alu_res to any output.
- FSM states: IDLE, APPLY, CHECK, DONE.
- IDLE: alu_a/alu_b/alu_op are driven 0. When start=1:
  - go to APPLY.
  - vec_idx=0.
  - table entry 0 is loaded onto alu_a/alu_b/alu_op.
  - err_count=0, fail_idx=4'hF, done=0, pass=0, busy=1.
- APPLY: hold the inputs for SETTLE_CYCLES cycles (counter counts down), then go to CHECK.
- CHECK (exactly one cycle): compare alu_res against the expected value for vec_idx.
  - On mismatch: err_count increments, saturating at 15. fail_idx=vec_idx only if fail_idx==4'hF.
  - If vec_idx==NUM_VEC-1: go to DONE.
  - Otherwise: vec_idx+1, load the next entry, return to APPLY.
- DONE:
  - busy=0, done=1, pass=(err_count==0).
  - alu_a/alu_b/alu_op are driven 0.
  - A start in DONE restarts exactly as from IDLE, clearing the results on the same edge.
- start while busy=1 is ignored.
- Latency: each vector takes SETTLE_CYCLES+1 cycles. If start is sampled at edge k, done rises at edge k+NUM_VEC*(SETTLE_CYCLES+1)+1. With SETTLE_CYCLES=1 that is k+25.
- Opcode encoding used: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, PASSB 1001, SRA 1101. Shift amounts are B[4:0].
- Vector table (idx: op A B -> expected, all values hex):
  - 0: ADD 0000000A 00000005 -> 0000000F
  - 1: SUB 0000000A 00000014 -> FFFFFFF6
  - 2: SLL 00000003 00000002 -> 0000000C
  - 3: SLT FFFFFFFB 00000003 -> 00000001
  - 4: SLTU FFFFFFFB 00000003 -> 00000000
  - 5: XOR F0F0F0F0 0F0F0F0F -> FFFFFFFF
  - 6: SRA FFFFFFC0 00000003 -> FFFFFFF8
  - 7: OR AAAA0000 0000BBBB -> AAAABBBB
  - 8: AND FFFF0000 00FF00FF -> 00FF0000
  - 9: PASSB 12345678 87654321 -> 87654321
  - 10: SRL FFFFFFC0 00000003 -> 1FFFFFF8
  - 11: SUB 00000005 00000005 -> 00000000

Test Plan:
- Correct ALU model, SETTLE_CYCLES=1, start pulse at edge k -> done=1 at k+25, pass=1, err_count=0, fail_idx=F; alu_op sequence 0,8,1,2,3,4,D,6,7,9,5,8.
- Faulty model that flips bit 0 on XOR only -> done, pass=0, err_count=1, fail_idx=5.
- Faulty model returning 0 always -> err_count=10 (idx 4 and 11 match), fail_idx=0, pass=0.
- rst asserted at vec_idx=6 mid-run -> next cycle all outputs at reset values; a new start completes a clean run with pass=1.
- start re-pulsed while busy, and again while done=1 -> the busy pulse has no effect; the done pulse restarts the run (done=0, err_count=0, vec_idx=0 on the same edge).
- SETTLE_CYCLES=3 -> each vector is held 3 cycles before CHECK; done at k+49.
